// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing controller.
//   state_e     : controller FSM states
//   *_DEF       : default parameter values for adder_share_ctrl
//   STAT_W      : width of the optional statistics counters
//   idw(n)      : index width for n requesters (at least 1 bit)
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int ADDER_LAT_DEF = 1;
    localparam int STAT_W        = 16;

    function automatic int idw(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request strictly after ptr, searching upward
// with wrap-around. The pointer register is owned by the caller.
// Ports:
//   req  in  N        request vector
//   ptr  in  idw(N)   index of the last winner
//   en   in  1        grant enable; gnt is all-zero when low
//   gnt  out N        one-hot grant (or zero)
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       req,
    input  logic [idw(N)-1:0]  ptr,
    input  logic               en,
    output logic [N-1:0]       gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        // Offsets 1..N visit every requester once; offset N is ptr itself,
        // so the previous winner has the lowest priority.
        for (int i = 1; i <= N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one external adder among NUM_REQ requesters with round-robin
// arbitration and a single operation in flight.
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (req_ready one-hot)
//   req_x/req_y              packed operands, requester i at [i*DATA_W +: DATA_W]
//   add_x/add_y/add_vld      operands and live flag driven to the adder
//   add_z                    adder sum (DATA_W+1 bits)
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/rsp_z             owner index and captured sum
//   dbg_state                current FSM state (state_e encoding)
// Optional feature (macro ADDER_SHARE_STATS_EN):
//   grant_cnt                per-requester accepted-handshake counters, 16 bits each
//   rsp_stall_cnt            cycles with rsp_valid & !rsp_ready
//
// Handshake rule: a transfer occurs on a posedge where valid and ready are
// both high; valid must not depend on ready, and response data is held
// stable while rsp_valid is high and rsp_ready is low.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDER_LAT = ADDER_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_x,
    input  logic [NUM_REQ*DATA_W-1:0]   req_y,
    output logic [DATA_W-1:0]           add_x,
    output logic [DATA_W-1:0]           add_y,
    output logic                        add_vld,
    input  logic [DATA_W:0]             add_z,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [idw(NUM_REQ)-1:0]     rsp_id,
    output logic [DATA_W:0]             rsp_z,
`ifdef ADDER_SHARE_STATS_EN
    output logic [NUM_REQ*STAT_W-1:0]   grant_cnt,
    output logic [STAT_W-1:0]           rsp_stall_cnt,
`endif
    output logic [1:0]                  dbg_state
);

    localparam int ID_W  = idw(NUM_REQ);
    localparam int CNT_W = $clog2(ADDER_LAT + 2);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   add_x_q, add_x_d;
    logic [DATA_W-1:0]   add_y_q, add_y_d;
    logic                add_vld_q, add_vld_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W:0]     rsp_z_q, rsp_z_d;
`ifdef ADDER_SHARE_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [STAT_W-1:0]         stall_cnt_q, stall_cnt_d;
`endif

    logic [NUM_REQ-1:0]  gnt;
    logic                arb_en;
    logic                handshake;
    logic [ID_W-1:0]     win_id;

    assign arb_en = (state_q == IDLE);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (gnt)
    );

    // gnt only ever selects a valid requester, so any grant is a handshake.
    assign handshake = |gnt;

    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        add_x_d     = add_x_q;
        add_y_d     = add_y_q;
        add_vld_d   = add_vld_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
`ifdef ADDER_SHARE_STATS_EN
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (handshake) begin
            grant_cnt_d[int'(win_id)*STAT_W +: STAT_W] =
                grant_cnt_q[int'(win_id)*STAT_W +: STAT_W] + STAT_W'(1);
        end
        if (rsp_valid_q && !rsp_ready) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    add_x_d   = req_x[int'(win_id)*DATA_W +: DATA_W];
                    add_y_d   = req_y[int'(win_id)*DATA_W +: DATA_W];
                    add_vld_d = 1'b1;
                    id_d      = win_id;
                    ptr_d     = win_id;
                    cnt_d     = CNT_W'(ADDER_LAT + 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // The edge that would take the counter to zero is the one
                // where add_z is valid for the registered operands.
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d       = '0;
                    rsp_z_d     = add_z;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    add_vld_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            cnt_q       <= '0;
            add_x_q     <= '0;
            add_y_q     <= '0;
            add_vld_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
`ifdef ADDER_SHARE_STATS_EN
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            add_x_q     <= add_x_d;
            add_y_q     <= add_y_d;
            add_vld_q   <= add_vld_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
`ifdef ADDER_SHARE_STATS_EN
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    assign req_ready = gnt;
    assign add_x     = add_x_q;
    assign add_y     = add_y_q;
    assign add_vld   = add_vld_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign dbg_state = state_q;
`ifdef ADDER_SHARE_STATS_EN
    assign grant_cnt     = grant_cnt_q;
    assign rsp_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl (NUM_REQ=4, DATA_W=8, ADDER_LAT=1).
// Includes a 1-cycle adder model driven by add_x/add_y.
module tb_adder_share_ctrl;

    localparam int NR = 4;
    localparam int DW = 8;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_x;
    logic [NR*DW-1:0] req_y;
    logic [DW-1:0]    add_x;
    logic [DW-1:0]    add_y;
    logic             add_vld;
    logic [DW:0]      add_z;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [DW:0]      rsp_z;
    logic [1:0]       dbg_state;
`ifdef ADDER_SHARE_STATS_EN
    logic [NR*16-1:0] grant_cnt;
    logic [15:0]      rsp_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    adder_share_ctrl #(.NUM_REQ(NR), .DATA_W(DW), .ADDER_LAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .add_x         (add_x),
        .add_y         (add_y),
        .add_vld       (add_vld),
        .add_z         (add_z),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_z         (rsp_z),
`ifdef ADDER_SHARE_STATS_EN
        .grant_cnt     (grant_cnt),
        .rsp_stall_cnt (rsp_stall_cnt),
`endif
        .dbg_state     (dbg_state)
    );

    // clock / adder model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        add_z <= {1'b0, add_x} + {1'b0, add_y};
    end

    // driver / checker tasks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int r, input logic [7:0] x, input logic [7:0] y);
        req_x[r*DW +: DW] = x;
        req_y[r*DW +: DW] = y;
    endtask

    task automatic wait_ready(input int r);
        int n;
        n = 0;
        #1;
        while (!req_ready[r] && n < 20) begin
            tick();
            n++;
        end
        chk("grant_timeout", 32'(n < 20), 32'd1);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("rsp_timeout", 32'(lat < 20), 32'd1);
    endtask

    task automatic do_op(input int r, input logic [7:0] x, input logic [7:0] y,
                         input logic [8:0] exp_z);
        int lat;
        set_ops(r, x, y);
        req_valid[r] = 1'b1;
        wait_ready(r);
        tick();
        req_valid[r] = 1'b0;
        wait_rsp(lat);
        chk("op_latency", 32'(lat), 32'd2);
        chk("op_rsp_id", 32'(rsp_id), 32'(r));
        chk("op_rsp_z", 32'(rsp_z), 32'(exp_z));
        tick();
        chk("op_rsp_cleared", 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        int         r;
        logic [7:0] x;
        logic [7:0] y;
        logic [8:0] z;
    } vec_t;

    vec_t vecs[8];

    logic [7:0] fx[4];
    logic [7:0] fy[4];
    logic [1:0] hold_id;
    logic [8:0] hold_z;
    int         lat;

    initial begin
        vecs[0] = '{0, 8'h12, 8'h34, 9'h046};
        vecs[1] = '{0, 8'hFF, 8'h01, 9'h100};
        vecs[2] = '{0, 8'hFF, 8'hFF, 9'h1FE};
        vecs[3] = '{1, 8'h00, 8'h00, 9'h000};
        vecs[4] = '{2, 8'h80, 8'h80, 9'h100};
        vecs[5] = '{3, 8'h7F, 8'h01, 9'h080};
        vecs[6] = '{1, 8'hA5, 8'h5A, 9'h0FF};
        vecs[7] = '{3, 8'hFF, 8'h00, 9'h0FF};
        fx = '{8'h11, 8'h22, 8'h33, 8'hF0};
        fy = '{8'h01, 8'h10, 8'hCD, 8'h20};

        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        repeat (3) @(posedge clk);
        #1;
        // reset values
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_add_x", 32'(add_x), 32'd0);
        chk("rst_add_y", 32'(add_y), 32'd0);
        chk("rst_add_vld", 32'(add_vld), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_z", 32'(rsp_z), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        tick();

        // table-driven single operations
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].r, vecs[i].x, vecs[i].y, vecs[i].z);
        end

        // operands and live flag during WAIT
        set_ops(2, 8'h3C, 8'h44);
        req_valid[2] = 1'b1;
        wait_ready(2);
        tick();
        req_valid[2] = 1'b0;
        chk("wait_add_vld", 32'(add_vld), 32'd1);
        chk("wait_add_x", 32'(add_x), 32'h3C);
        chk("wait_add_y", 32'(add_y), 32'h44);
        chk("wait_req_ready", 32'(req_ready), 32'd0);
        wait_rsp(lat);
        chk("wait_rsp_z", 32'(rsp_z), 32'h080);
        chk("rsp_add_vld", 32'(add_vld), 32'd0);
        tick();

        // fairness: fresh reset so requester 0 wins first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_ops(i, fx[i], fy[i]);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_rsp(lat);
            chk("rr_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_z", 32'(rsp_z), 32'({1'b0, fx[k % 4]} + {1'b0, fy[k % 4]}));
            tick();
        end
        req_valid = '0;
        tick();

        // backpressure: response held for 5 stalled cycles
        rsp_ready = 1'b0;
        set_ops(0, 8'h40, 8'hC1);
        set_ops(1, 8'h05, 8'h06);
        req_valid = 4'b0011;
        wait_ready(0);
        tick();
        req_valid[0] = 1'b0;
        wait_rsp(lat);
        hold_id = rsp_id;
        hold_z  = rsp_z;
        chk("bp_first_id", 32'(hold_id), 32'd0);
        chk("bp_first_z", 32'(hold_z), 32'h101);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid_held", 32'(rsp_valid), 32'd1);
            chk("bp_id_held", 32'(rsp_id), 32'(hold_id));
            chk("bp_z_held", 32'(rsp_z), 32'(hold_z));
            chk("bp_no_ready", 32'(req_ready), 32'd0);
        end
`ifdef ADDER_SHARE_STATS_EN
        chk("bp_stall_cnt", 32'(rsp_stall_cnt), 32'd5);
`endif
        rsp_ready = 1'b1;
        tick();
        chk("bp_released", 32'(rsp_valid), 32'd0);
        chk("bp_pending_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(lat);
        chk("bp_second_id", 32'(rsp_id), 32'd1);
        chk("bp_second_z", 32'(rsp_z), 32'h00B);
        tick();

        // reset one cycle after handshake aborts the op
        set_ops(1, 8'h10, 8'h20);
        req_valid[1] = 1'b1;
        wait_ready(1);
        tick();
        req_valid[1] = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_add_vld", 32'(add_vld), 32'd0);
        chk("abort_add_x", 32'(add_x), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_op(2, 8'h21, 8'h43, 9'h064);

        // late valid: req3 raised while req1 is in WAIT
        set_ops(1, 8'h01, 8'h02);
        set_ops(3, 8'hE0, 8'h30);
        req_valid[1] = 1'b1;
        wait_ready(1);
        tick();
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1;
        #1;
        chk("late_blocked", 32'(req_ready), 32'd0);
        wait_rsp(lat);
        chk("late_first_id", 32'(rsp_id), 32'd1);
        chk("late_first_z", 32'(rsp_z), 32'h003);
        tick();
        chk("late_granted", 32'(req_ready), 32'b1000);
        tick();
        req_valid[3] = 1'b0;
        wait_rsp(lat);
        chk("late_second_id", 32'(rsp_id), 32'd3);
        chk("late_second_z", 32'(rsp_z), 32'h110);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
